// File: rtl/mem_if_pkg.sv
// Shared types for the data-side SRAM-like responder: size codes, queue entry
// layout and the byte-lane merge used when a write commits.
package mem_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int IDX_W = 30;

  typedef struct packed {
    logic             wr;
    logic [3:0]       wstrb;
    logic [IDX_W-1:0] idx;
    logic [31:0]      wdata;
    logic [3:0]       cnt;
  } entry_t;

  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/resp_queue.sv
// In-order circular queue of accepted requests; every live entry counts its
// own latency down, and only the head is ever offered for popping.
module resp_queue
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     head_valid,
  output logic                     head_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] count_q, count_d;

  entry_t           slot_view [DEPTH];
  logic [DEPTH-1:0] valid_view;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      entry_t slot_q, slot_d;
      logic   valid_q, valid_d;

      // A freshly pushed entry overrides the decrement, so it starts at LAT-1.
      always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q;
        if (valid_q && (slot_q.cnt != 4'd0)) slot_d.cnt = slot_q.cnt - 4'd1;
        if (pop && (rd_ptr_q == PW'(gi))) valid_d = 1'b0;
        if (push && (wr_ptr_q == PW'(gi))) begin
          slot_d  = push_entry;
          valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= valid_d;
        slot_q <= slot_d;
      end

      assign slot_view[gi]  = slot_q;
      assign valid_view[gi] = valid_q;
    end
  endgenerate

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + OW'(push) - OW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head       = slot_view[rd_ptr_q];
  assign head_valid = valid_view[rd_ptr_q];
  assign head_ready = (head.cnt == 4'd0);
  assign occupancy  = count_q;

  assert property (@(posedge clk) disable iff (reset)
                   !(push && (count_q == OW'(DEPTH))));

endmodule

// File: rtl/data_sram_responder.sv
// Responder for the data SRAM-like handshake: word-addressed memory behind a
// fixed-latency, strictly in-order response queue.
module data_sram_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LAT    = 2,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      data_sram_req,
  input  logic                      data_sram_wr,
  input  logic [1:0]                data_sram_size,
  input  logic [3:0]                data_sram_wstrb,
  input  logic [31:0]               data_sram_addr,
  input  logic [31:0]               data_sram_wdata,
  output logic                      data_sram_addr_ok,
  output logic                      data_sram_data_ok,
  output logic [31:0]               data_sram_rdata,
  input  logic                      hold,
  output logic [$clog2(QDEPTH):0]   occupancy
);

  localparam int OCC_W = $clog2(QDEPTH) + 1;

  logic [31:0] mem [2**ADDR_W];

  entry_t             push_entry;
  entry_t             head;
  logic               head_valid;
  logic               head_ready;
  logic               push;
  logic               pop;
  logic [OCC_W-1:0]   occ;
  logic [ADDR_W-1:0]  head_idx;

  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;

  // No pop-through: a full queue refuses even when the head leaves this edge.
  assign data_sram_addr_ok = ~reset & ~hold & (occ < OCC_W'(QDEPTH));
  assign push              = data_sram_req & data_sram_addr_ok;
  assign pop               = head_valid & head_ready & ~reset;

  always_comb begin
    push_entry       = '0;
    push_entry.wr    = data_sram_wr;
    push_entry.wstrb = data_sram_wstrb;
    push_entry.idx   = IDX_W'(data_sram_addr[ADDR_W+1:2]);
    push_entry.wdata = data_sram_wdata;
    push_entry.cnt   = 4'(LAT - 1);
  end

  resp_queue #(
    .DEPTH(QDEPTH)
  ) u_resp_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .head_ready (head_ready),
    .occupancy  (occ)
  );

  assign head_idx  = head.idx[ADDR_W-1:0];
  assign occupancy = occ;

  // Writes commit at their own pop, so later reads in the queue see them.
  always_ff @(posedge clk) begin
    if (pop && head.wr) begin
      mem[head_idx] <= wstrb_merge(mem[head_idx], head.wdata, head.wstrb);
    end
  end

  always_comb begin
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;
    if (pop) begin
      data_ok_d = 1'b1;
      rdata_d   = head.wr ? 32'd0 : mem[head_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = rdata_q;

  // Size and low address bits are informational; alignment is the initiator's job.
  logic size_is_word;
  logic size_is_sub;
  logic unused_bits;
  assign size_is_word = (data_sram_size == SZ_WORD) | (data_sram_size == 2'd3);
  assign size_is_sub  = (data_sram_size == SZ_BYTE) | (data_sram_size == SZ_HALF);
  assign unused_bits  = ^{size_is_word, size_is_sub, data_sram_addr, head.idx};

endmodule

// File: tb/tb_data_sram_responder.sv
// Three responders (LAT 2, 8, 1) share one randomized/directed stimulus stream;
// each is checked against a time-stamped in-order reference model.
module tb_data_sram_responder;

  localparam int NI = 3;
  localparam int QD = 4;
  localparam int AW = 12;
  localparam logic [11:0] LATS = {4'd1, 4'd8, 4'd2};

  logic        clk = 1'b0;
  logic        reset, req, wr, hold;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;

  logic        addr_ok [NI];
  logic        data_ok [NI];
  logic [31:0] rdata   [NI];
  logic [2:0]  occ     [NI];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      data_sram_responder #(
        .ADDR_W (AW),
        .LAT    (int'(LATS[gi*4 +: 4])),
        .QDEPTH (QD)
      ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (req),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_wstrb   (wstrb),
        .data_sram_addr    (addr),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (addr_ok[gi]),
        .data_sram_data_ok (data_ok[gi]),
        .data_sram_rdata   (rdata[gi]),
        .hold              (hold),
        .occupancy         (occ[gi])
      );
    end
  endgenerate

  typedef struct {
    int          due;
    bit          wr;
    logic [3:0]  strb;
    int          idx;
    logic [31:0] wdata;
  } op_t;

  op_t         ring   [NI][16];
  int          rhead  [NI];
  int          rtail  [NI];
  logic [31:0] mm     [NI][4096];
  bit          mv     [NI][4096];
  bit          exp_dok   [NI];
  logic [31:0] exp_rd    [NI];
  bit          exp_known [NI];
  bit          exp_aok   [NI];
  int          edge_n;
  int          checks = 0;
  int          errors = 0;

  function automatic int lat_of(int i);
    return int'(LATS[i*4 +: 4]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%h required=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge(input int i);
    op_t         op;
    logic [31:0] mask;
    if (reset) begin
      rhead[i]     = rtail[i];
      exp_dok[i]   = 1'b0;
      exp_rd[i]    = 32'd0;
      exp_known[i] = 1'b1;
      return;
    end
    exp_dok[i] = 1'b0;
    if (rtail[i] > rhead[i] && ring[i][rhead[i] % 16].due <= edge_n) begin
      op = ring[i][rhead[i] % 16];
      rhead[i]++;
      exp_dok[i] = 1'b1;
      if (op.wr) begin
        mask = {{8{op.strb[3]}}, {8{op.strb[2]}}, {8{op.strb[1]}}, {8{op.strb[0]}}};
        mm[i][op.idx] = (mm[i][op.idx] & ~mask) | (op.wdata & mask);
        if (op.strb == 4'hF) mv[i][op.idx] = 1'b1;
        exp_rd[i]    = 32'd0;
        exp_known[i] = 1'b1;
      end else begin
        exp_rd[i]    = mm[i][op.idx];
        exp_known[i] = mv[i][op.idx];
      end
      $display("resp inst%0d edge %0d %s idx %03h value %h", i, edge_n,
               op.wr ? "wr" : "rd", op.idx, op.wr ? op.wdata : exp_rd[i]);
    end
    if (req && exp_aok[i]) begin
      op.due   = edge_n + lat_of(i);
      op.wr    = wr;
      op.strb  = wstrb;
      op.idx   = int'(addr[AW+1:2]);
      op.wdata = wdata;
      ring[i][rtail[i] % 16] = op;
      rtail[i]++;
    end
  endtask

  task automatic step();
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_aok[i] = !reset && !hold && ((rtail[i] - rhead[i]) < QD);
      check($sformatf("addr_ok[%0d]", i), 32'(addr_ok[i]), 32'(exp_aok[i]));
    end
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < NI; i++) model_edge(i);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("data_ok[%0d]", i), 32'(data_ok[i]), 32'(exp_dok[i]));
      check($sformatf("occupancy[%0d]", i), 32'(occ[i]), 32'(rtail[i] - rhead[i]));
      if (exp_known[i]) check($sformatf("rdata[%0d]", i), rdata[i], exp_rd[i]);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req   = r;
    wr    = w;
    wstrb = s;
    addr  = a;
    wdata = d;
    size  = 2'd2;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (n) step();
  endtask

  initial begin
    int peak;
    edge_n = 0;
    for (int i = 0; i < NI; i++) begin
      rhead[i] = 0; rtail[i] = 0;
      exp_dok[i] = 1'b0; exp_rd[i] = 32'd0; exp_known[i] = 1'b0;
      for (int k = 0; k < 4096; k++) begin
        mm[i][k] = 32'd0;
        mv[i][k] = 1'b0;
      end
    end
    reset = 1'b1;
    hold  = 1'b0;
    idle(3);
    reset = 1'b0;

    // Write then read the same word.
    drive(1'b1, 1'b1, 4'hF, 32'h40, 32'h12345678); step();
    drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);        step();
    idle(10);
    for (int i = 0; i < NI; i++) check($sformatf("wr_rd_word[%0d]", i), rdata[i], 32'h12345678);

    // Byte-lane merge.
    drive(1'b1, 1'b1, 4'hF, 32'h80, 32'hAABBCCDD); step();
    drive(1'b1, 1'b1, 4'h2, 32'h81, 32'h11111111); step();
    drive(1'b1, 1'b0, 4'h0, 32'h80, 32'h0);        step();
    idle(10);
    for (int i = 0; i < NI; i++) check($sformatf("byte_merge[%0d]", i), rdata[i], 32'hAABB11DD);

    // Back-to-back reads: fills the LAT=8 queue, streams through the LAT=1 one.
    peak = 0;
    drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    for (int c = 0; c < 12; c++) begin
      step();
      if (int'(occ[1]) > peak) peak = int'(occ[1]);
    end
    check("full_peak_occ", 32'(peak), 32'(QD));
    idle(12);

    // Reset with requests in flight; committed memory must survive.
    drive(1'b1, 1'b1, 4'hF, 32'h200, 32'hCAFEF00D); step();
    idle(12);
    drive(1'b1, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF);
    repeat (3) step();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1; step();
    reset = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 32'h200, 32'h0); step();
    idle(12);
    check("reset_keeps_mem", rdata[1], 32'hCAFEF00D);

    // Hold blocks acceptance; address wraps modulo memory size.
    hold = 1'b1;
    drive(1'b1, 1'b1, 4'hF, 32'h4000, 32'h5A5AA5A5);
    repeat (4) step();
    hold = 1'b0;
    step();
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0); step();
    idle(12);
    for (int i = 0; i < NI; i++) check($sformatf("wrap[%0d]", i), rdata[i], 32'h5A5AA5A5);

    // Randomized traffic over a small word set with aliased upper address bits.
    for (int c = 0; c < 600; c++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1), s, a, $urandom);
      hold  = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    hold  = 1'b0;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
